// File: rtl/req_pending_latch.sv
// Sticky pending/overflow latch feeding a 4-input priority encoder.
// Optional build macro REQ_SYNC_EN adds a 2-flop input synchronizer per request line.
module req_pending_latch #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    mask_i,
  input  logic            ack_i,
  input  logic [IDXW-1:0] ack_idx_i,
  input  logic            ovf_clr_i,
  output logic [N-1:0]    pend_o,
  output logic            any_o,
  output logic [N-1:0]    ovf_o
);

  logic [N-1:0] req_s;
  logic [N-1:0] req_q;
  logic [N-1:0] rise_s;
  logic [N-1:0] set_s;
  logic [N-1:0] clr_s;
  logic [N-1:0] pend_d;
  logic [N-1:0] pend_q;
  logic [N-1:0] ovf_d;
  logic [N-1:0] ovf_q;

`ifdef REQ_SYNC_EN
  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;

  // Two-stage synchronizer for requests asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= {N{1'b0}};
      sync2_q <= {N{1'b0}};
    end else begin
      sync1_q <= req_i;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = req_i;
`endif

  // Edge detect, ack decode and next-state for pending and overflow bits.
  always_comb begin
    rise_s = req_s & ~req_q;
    set_s  = rise_s & ~mask_i;
    clr_s  = {N{1'b0}};
    for (int k = 0; k < N; k++) begin
      // An out-of-range index matches no line, so the ack is dropped.
      if (ack_i && (int'(ack_idx_i) == k)) begin
        clr_s[k] = 1'b1;
      end else begin
        clr_s[k] = 1'b0;
      end
    end
    pend_d = (pend_q & ~clr_s) | set_s;
    ovf_d  = (ovf_clr_i ? {N{1'b0}} : ovf_q) | (set_s & pend_q & ~clr_s);
  end

  // History zero after reset: a line held high through reset counts as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= {N{1'b0}};
      pend_q <= {N{1'b0}};
      ovf_q  <= {N{1'b0}};
    end else begin
      req_q  <= req_s;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;
  assign any_o  = |pend_q;

endmodule
